// File: rtl/cache_ctrl_2way.sv
// Controller for a 2-way set-associative, write-through, one-word-per-line cache with synchronous-read RAMs.
// Define CACHE_STATS_EN to enable the saturating hit/miss counters; otherwise both counters read as zero.
module cache_ctrl_2way #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 13,
  parameter int DWIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [AWIDTH+TWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0]        req_wdata,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [DWIDTH-1:0]        resp_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [AWIDTH+TWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DWIDTH-1:0]        mem_rdata,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [DWIDTH-1:0]        data_din,
  output logic                     d0_we,
  output logic                     d1_we,
  input  logic [DWIDTH-1:0]        d0_dout,
  input  logic [DWIDTH-1:0]        d1_dout,
  output logic [TWIDTH:0]          tag_din,
  output logic                     t0_we,
  output logic                     t1_we,
  input  logic [TWIDTH:0]          t0_dout,
  input  logic [TWIDTH:0]          t1_dout,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);
  localparam int SETS = 1 << AWIDTH;
  localparam int MAW  = AWIDTH + TWIDTH;

  typedef enum logic [1:0] {IDLE, COMPARE, FILL, WMEM} state_t;

  state_t              state_q, state_d;
  logic [MAW-1:0]      addr_q, addr_d;
  logic                we_q, we_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                victim_q, victim_d;
  logic [SETS-1:0]     lru_q, lru_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [MAW-1:0]      mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic [AWIDTH-1:0]   idx;
  logic [TWIDTH-1:0]   tag;
  logic                hit0, hit1, hit;

  assign idx  = addr_q[AWIDTH-1:0];
  assign tag  = addr_q[MAW-1:AWIDTH];
  // Way 0 wins if both ways ever claim the line.
  assign hit0 = t0_dout[TWIDTH] && (t0_dout[TWIDTH-1:0] == tag);
  assign hit1 = !hit0 && t1_dout[TWIDTH] && (t1_dout[TWIDTH-1:0] == tag);
  assign hit  = hit0 | hit1;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    lru_d       = lru_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    ram_addr    = idx;
    data_din    = wdata_q;
    tag_din     = {1'b1, tag};
    d0_we       = 1'b0;
    d1_we       = 1'b0;
    t0_we       = 1'b0;
    t1_we       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        ram_addr  = req_addr[AWIDTH-1:0];
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (we_q) begin
          state_d     = WMEM;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          if (hit) begin
            d0_we      = hit0;
            d1_we      = hit1;
            lru_d[idx] = hit0;
          end
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = hit0 ? d0_dout : d1_dout;
          lru_d[idx] = hit0;
          state_d    = IDLE;
        end else begin
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
          victim_d   = !t0_dout[TWIDTH] ? 1'b0 :
                       (!t1_dout[TWIDTH] ? 1'b1 : lru_q[idx]);
        end
      end
      FILL: begin
        data_din = mem_rdata;
        if (mem_ack) begin
          d0_we      = !victim_q;
          d1_we      = victim_q;
          t0_we      = !victim_q;
          t1_we      = victim_q;
          resp_valid = 1'b1;
          resp_rdata = mem_rdata;
          lru_d[idx] = !victim_q;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      WMEM: begin
        if (mem_ack) begin
          resp_valid = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle aborts any completion: no RAM update and no response.
    if (reset) begin
      d0_we      = 1'b0;
      d1_we      = 1'b0;
      t0_we      = 1'b0;
      t1_we      = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      victim_q    <= 1'b0;
      lru_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      victim_q    <= victim_d;
      lru_q       <= lru_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == COMPARE) begin
      if (hit) hit_count_d  = sat_inc(hit_count_q);
      else     miss_count_d = sat_inc(miss_count_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Randomized bench for cache_ctrl_2way: behavioural RAMs and backing memory plus a set/way/LRU cache model.
module tb_cache_ctrl_2way;
  localparam int AW  = 3;
  localparam int TW  = 13;
  localparam int DW  = 32;
  localparam int MAW = AW + TW;

  logic           clock, reset;
  logic           req_valid, req_we, req_ready;
  logic [MAW-1:0] req_addr;
  logic [DW-1:0]  req_wdata;
  logic           resp_valid;
  logic [DW-1:0]  resp_rdata;
  logic           mem_req, mem_we, mem_ack;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic [AW-1:0]  ram_addr;
  logic [DW-1:0]  data_din, d0_dout, d1_dout;
  logic           d0_we, d1_we, t0_we, t1_we;
  logic [TW:0]    tag_din, t0_dout, t1_dout;
  logic [15:0]    hit_count, miss_count;

  cache_ctrl_2way #(.AWIDTH(AW), .TWIDTH(TW), .DWIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .data_din(data_din), .d0_we(d0_we), .d1_we(d1_we),
    .d0_dout(d0_dout), .d1_dout(d1_dout), .tag_din(tag_din), .t0_we(t0_we), .t1_we(t1_we),
    .t0_dout(t0_dout), .t1_dout(t1_dout), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAMs with a preload port used only while the controller is held in reset.
  logic [DW-1:0] d0m [8];
  logic [DW-1:0] d1m [8];
  logic [TW:0]   t0m [8];
  logic [TW:0]   t1m [8];
  logic          pl_en, pl_way;
  logic [AW-1:0] pl_idx;
  logic [TW:0]   pl_tag;
  logic [DW-1:0] pl_data;

  always @(posedge clock) begin
    if (pl_en) begin
      if (pl_way) begin t1m[pl_idx] <= pl_tag; d1m[pl_idx] <= pl_data; end
      else        begin t0m[pl_idx] <= pl_tag; d0m[pl_idx] <= pl_data; end
    end
    if (d0_we) d0m[ram_addr] <= data_din;
    if (d1_we) d1m[ram_addr] <= data_din;
    if (t0_we) t0m[ram_addr] <= tag_din;
    if (t1_we) t1m[ram_addr] <= tag_din;
    d0_dout <= d0m[ram_addr];
    d1_dout <= d1m[ram_addr];
    t0_dout <= t0m[ram_addr];
    t1_dout <= t1m[ram_addr];
  end

  // Reference cache state: per-way valid/tag/data, per-set "replace next" way, event counts.
  logic          mv [2][8];
  logic [TW-1:0] mt [2][8];
  logic [DW-1:0] md [2][8];
  logic          ml [8];
  int            exp_hits, exp_misses;

  int checks, errors;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_counts(input string tag);
`ifdef CACHE_STATS_EN
    check_eq(tag, {hit_count, miss_count}, {16'(exp_hits), 16'(exp_misses)});
`else
    check_eq(tag, {hit_count, miss_count}, 64'd0);
`endif
  endtask

  task automatic preload(input int way, input int idx, input logic v,
                         input logic [TW-1:0] tg, input logic [DW-1:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_way = way[0]; pl_idx = idx[AW-1:0]; pl_tag = {v, tg}; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
    mv[way][idx] = v; mt[way][idx] = tg; md[way][idx] = d;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) ml[s] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // One full CPU transaction; dly = FILL/WMEM cycles before mem_ack, rdv = backing-memory read data.
  task automatic do_req(input logic we, input logic [MAW-1:0] addr, input logic [DW-1:0] wd,
                        input int dly, input logic [DW-1:0] rdv);
    logic [AW-1:0] idx;
    logic [TW-1:0] tg;
    logic          h0, h1, hit, pre_ok;
    int            hw, vic;
    idx = addr[AW-1:0];
    tg  = addr[MAW-1:AW];
    h0  = mv[0][idx] && (mt[0][idx] == tg);
    h1  = !h0 && mv[1][idx] && (mt[1][idx] == tg);
    hit = h0 || h1;
    hw  = h1 ? 1 : 0;
    vic = !mv[0][idx] ? 0 : (!mv[1][idx] ? 1 : int'(ml[idx]));

    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    #1;
    check_eq("req_ready", req_ready, 1);
    check_eq("ram_addr_idle", ram_addr, idx);
    @(negedge clock);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
    #1;
    if (hit) exp_hits++; else exp_misses++;
    check_eq("cmp_ram_addr", ram_addr, idx);
    if (!we && hit) begin
      check_eq("rd_hit_resp", resp_valid, 1);
      check_eq("rd_hit_data", resp_rdata, md[hw][idx]);
      check_eq("rd_hit_we", {t1_we, t0_we, d1_we, d0_we}, 0);
      ml[idx] = (hw == 0);
      @(negedge clock); #1;
      check_eq("rd_hit_mem_req", mem_req, 0);
      check_eq("rd_hit_ready", req_ready, 1);
      check_eq("rd_hit_resp_end", resp_valid, 0);
    end else begin
      check_eq("cmp_resp", resp_valid, 0);
      if (we && hit) begin
        check_eq("wr_hit_we", {t1_we, t0_we, d1_we, d0_we}, (hw == 1) ? 4'b0010 : 4'b0001);
        check_eq("wr_hit_din", data_din, wd);
        md[hw][idx] = wd;
        ml[idx] = (hw == 0);
      end else begin
        check_eq("cmp_no_we", {t1_we, t0_we, d1_we, d0_we}, 0);
      end
      pre_ok = 1'b1;
      for (int n = 0; n <= dly; n++) begin
        @(negedge clock);
        if (n == dly) begin mem_ack = 1'b1; mem_rdata = rdv; end
        else mem_rdata = $urandom;
        #1;
        if (n < dly && (!mem_req || resp_valid || ({t1_we, t0_we, d1_we, d0_we} != 0)))
          pre_ok = 1'b0;
      end
      check_eq("mem_hold", pre_ok, 1);
      check_eq("ack_mem_req", mem_req, 1);
      check_eq("ack_mem_we", mem_we, we);
      check_eq("ack_mem_addr", mem_addr, addr);
      if (we) check_eq("ack_mem_wdata", mem_wdata, wd);
      check_eq("ack_resp", resp_valid, 1);
      if (!we) begin
        check_eq("fill_rdata", resp_rdata, rdv);
        check_eq("fill_we", {t1_we, t0_we, d1_we, d0_we}, (vic == 1) ? 4'b1010 : 4'b0101);
        check_eq("fill_din", data_din, rdv);
        check_eq("fill_tag", tag_din, {1'b1, tg});
        mv[vic][idx] = 1'b1; mt[vic][idx] = tg; md[vic][idx] = rdv;
        ml[idx] = (vic == 0);
      end else begin
        check_eq("wmem_no_we", {t1_we, t0_we, d1_we, d0_we}, 0);
      end
      @(negedge clock);
      mem_ack = 1'b0;
      #1;
      check_eq("post_mem_req", mem_req, 0);
      check_eq("post_resp", resp_valid, 0);
      check_eq("post_ready", req_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; pl_en = 1'b0; pl_way = 1'b0; pl_idx = '0;
    pl_tag = '0; pl_data = '0;
    repeat (2) @(negedge clock);
    for (int s = 0; s < 8; s++) begin
      preload(0, s, 1'b0, '0, '0);
      preload(1, s, 1'b0, '0, '0);
    end
    preload(0, 3, 1'b1, 13'h0015, 32'hDEADBEEF);
    model_reset();
    @(negedge clock); #1;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_resp", {resp_valid, resp_rdata}, 0);
    check_eq("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check_eq("rst_we", {t1_we, t0_we, d1_we, d0_we}, 0);
    check_counts("rst_counts");
    @(negedge clock);
    reset = 1'b0;

    // Directed: preloaded hit, cold miss and re-read, LRU replacement in set 2.
    do_req(1'b0, 16'h00AB, '0, 0, '0);
    do_req(1'b0, 16'h0102, '0, 3, 32'h12345678);
    do_req(1'b0, 16'h0102, '0, 0, '0);
    do_req(1'b0, 16'h020A, '0, 1, 32'hA5A5_0001);
    do_req(1'b0, 16'h0102, '0, 0, '0);
    do_req(1'b0, 16'h030A, '0, 2, 32'hA5A5_0002);
    do_req(1'b0, 16'h040A, '0, 0, 32'hA5A5_0003);
    do_req(1'b0, 16'h030A, '0, 0, '0);
    // Write hit then read-back, then write miss with no allocation.
    do_req(1'b1, 16'h00AB, 32'hCAFEF00D, 2, '0);
    do_req(1'b0, 16'h00AB, '0, 0, '0);
    do_req(1'b1, 16'h7FF3, 32'h0BAD_0BAD, 1, '0);
    do_req(1'b0, 16'h7FF3, '0, 0, 32'h7777_0000);

    // Stray mem_ack in IDLE has no effect.
    @(negedge clock); mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
    check_eq("idle_ack_resp", resp_valid, 0);
    check_eq("idle_ack_we", {t1_we, t0_we, d1_we, d0_we}, 0);
    @(negedge clock); mem_ack = 1'b0; #1;
    check_eq("idle_ack_ready", req_ready, 1);
    check_eq("idle_ack_mem_req", mem_req, 0);

    // Reset while in FILL, with a coincident mem_ack that must be dropped.
    @(negedge clock); req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hFFFD; #1;
    @(negedge clock); req_valid = 1'b0; #1;
    @(negedge clock); #1;
    check_eq("fill_mem_req", mem_req, 1);
    @(negedge clock); reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
    check_eq("rst_fill_we", {t1_we, t0_we, d1_we, d0_we}, 0);
    check_eq("rst_fill_resp", resp_valid, 0);
    @(negedge clock); reset = 1'b0; mem_ack = 1'b0; #1;
    check_eq("rst_fill_mem_req", mem_req, 0);
    check_eq("rst_fill_ready", req_ready, 1);
    model_reset();
    check_counts("rst_fill_counts");

    // Three hits and two misses from cleared counters.
    do_req(1'b0, 16'h00AB, '0, 0, '0);
    do_req(1'b0, 16'hFFFD, '0, 1, 32'h1111_2222);
    do_req(1'b0, 16'h00AB, '0, 0, '0);
    do_req(1'b0, 16'hFFFE, '0, 0, 32'h3333_4444);
    do_req(1'b0, 16'hFFFD, '0, 0, '0);
    check_counts("counts_3h_2m");

    // Random traffic over a small tag pool so hits, misses and evictions all occur.
    for (int i = 0; i < 150; i++) begin
      logic [MAW-1:0] a;
      a = {13'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      do_req(1'($urandom_range(0, 3) == 0), a, $urandom, int'($urandom_range(0, 4)), $urandom);
    end
    check_counts("final_counts");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
